// File: rtl/cache_refill_buffer_pkg.sv
// Shared definitions for the cache line refill path: FSM state encoding,
// line geometry and read-mux hit encodings.
package cache_refill_buffer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_RECV  = 2'd2,
      ST_WRITE = 2'd3
   } state_t;

   localparam int LINE_WORDS = 4;
   localparam int CNT_W      = $clog2(LINE_WORDS);
   localparam int OFFSET_LSB = 2;
   localparam int OFFSET_MSB = 3;

   localparam logic [1:0] HIT_WAY1 = 2'b01;
   localparam logic [1:0] HIT_WAY2 = 2'b10;
   localparam logic [1:0] HIT_NONE = 2'b00;

endpackage

// File: rtl/cache_refill_buffer_line_assembler.sv
// Collects returned memory beats into one cache line, tracking which
// words have landed so the miss path can release on the critical word.
module cache_refill_buffer_line_assembler
   import cache_refill_buffer_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic                         beat_we,
   input  logic [WORD_W-1:0]            beat_data,
   output logic [CNT_W-1:0]             cnt,
   output logic [WORD_W*LINE_WORDS-1:0] m_data,
   output logic [LINE_WORDS-1:0]        word_valid
);

   logic [LINE_WORDS-1:0] lane_we;

   // Beats arrive in ascending word order, so the counter selects the lane.
   always_comb begin
      lane_we = '0;
      if (beat_we) begin
         lane_we[cnt] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt        <= '0;
         m_data     <= '0;
         word_valid <= '0;
      end else if (beat_we) begin
         for (int n = 0; n < LINE_WORDS; n++) begin
            if (lane_we[n]) begin
               m_data[n*WORD_W +: WORD_W] <= beat_data;
               word_valid[n]              <= 1'b1;
            end
         end
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/cache_refill_buffer.sv
// Refill engine for the cache write side: issues one line read on a miss,
// assembles the returned beats and writes the line into the victim way.
module cache_refill_buffer
   import cache_refill_buffer_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int WORD_W     = 32,
   parameter int LINE_WORDS = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         miss_req,
   input  logic [ADDR_W-1:0]            miss_addr,
   input  logic [1:0]                   miss_way,
   output logic                         busy,
   output logic                         mem_rd_req,
   output logic [ADDR_W-1:0]            mem_rd_addr,
   input  logic                         mem_rd_ack,
   input  logic                         ret_valid,
   input  logic [WORD_W-1:0]            ret_data,
   input  logic                         ret_last,
   output logic [WORD_W*LINE_WORDS-1:0] m_data,
   output logic [LINE_WORDS-1:0]        word_valid,
   output logic                         crit_ready,
   output logic                         wr_en,
   output logic [1:0]                   wr_way,
   output logic [ADDR_W-1:0]            wr_addr,
   output logic                         refill_done,
   output logic                         proto_err
);

   state_t                   state;
   logic [ADDR_W-1:0]        line_addr_q;
   logic [1:0]               crit_idx_q;
   logic [1:0]               way_q;
   logic [CNT_W-1:0]         cnt;
   logic                     clr;
   logic                     beat_we;
   logic                     final_beat;
   logic                     unused_byte_offset;

   assign unused_byte_offset = ^miss_addr[OFFSET_LSB-1:0];

   assign clr        = (state == ST_IDLE) && miss_req;
   assign beat_we    = (state == ST_RECV) && ret_valid;
   assign final_beat = (cnt == CNT_W'(LINE_WORDS - 1));

   cache_refill_buffer_line_assembler #(
      .WORD_W    (WORD_W)
   ) u_line_assembler (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .beat_we    (beat_we),
      .beat_data  (ret_data),
      .cnt        (cnt),
      .m_data     (m_data),
      .word_valid (word_valid)
   );

   // Refill sequencing; a beat outside RECV never reaches the assembler.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         mem_rd_req  <= 1'b0;
         line_addr_q <= '0;
         crit_idx_q  <= '0;
         way_q       <= '0;
         wr_en       <= 1'b0;
         refill_done <= 1'b0;
         proto_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (miss_req) begin
                  line_addr_q <= {miss_addr[ADDR_W-1:OFFSET_MSB+1], {(OFFSET_MSB+1){1'b0}}};
                  crit_idx_q  <= miss_addr[OFFSET_MSB:OFFSET_LSB];
                  way_q       <= miss_way;
                  mem_rd_req  <= 1'b1;
                  busy        <= 1'b1;
                  state       <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (mem_rd_ack) begin
                  mem_rd_req <= 1'b0;
                  state      <= ST_RECV;
               end
            end
            ST_RECV: begin
               if (beat_we) begin
                  // ret_last must coincide exactly with the fourth beat.
                  if (ret_last != final_beat) begin
                     proto_err <= 1'b1;
                  end
                  if (final_beat) begin
                     wr_en       <= 1'b1;
                     refill_done <= 1'b1;
                     state       <= ST_WRITE;
                  end
               end
            end
            ST_WRITE: begin
               wr_en       <= 1'b0;
               refill_done <= 1'b0;
               busy        <= 1'b0;
               state       <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_rd_addr = line_addr_q;
   assign wr_addr     = line_addr_q;
   assign wr_way      = way_q;
   assign crit_ready  = word_valid[crit_idx_q];

endmodule

// File: tb/tb_cache_refill_buffer.sv
// Scoreboard bench for cache_refill_buffer: directed scenarios then random
// refills, each line write checked against a queue of expected refills.
module tb_cache_refill_buffer;

   localparam int ADDR_W = 32;
   localparam int WORD_W = 32;
   localparam int LINE_W = 128;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              miss_req = 1'b0;
   logic [ADDR_W-1:0] miss_addr = '0;
   logic [1:0]        miss_way = '0;
   logic              busy;
   logic              mem_rd_req;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic              mem_rd_ack = 1'b0;
   logic              ret_valid = 1'b0;
   logic [WORD_W-1:0] ret_data = '0;
   logic              ret_last = 1'b0;
   logic [LINE_W-1:0] m_data;
   logic [3:0]        word_valid;
   logic              crit_ready;
   logic              wr_en;
   logic [1:0]        wr_way;
   logic [ADDR_W-1:0] wr_addr;
   logic              refill_done;
   logic              proto_err;

   always #5 clk = ~clk;

   cache_refill_buffer dut (
      .clk         (clk),
      .rst         (rst),
      .miss_req    (miss_req),
      .miss_addr   (miss_addr),
      .miss_way    (miss_way),
      .busy        (busy),
      .mem_rd_req  (mem_rd_req),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_ack  (mem_rd_ack),
      .ret_valid   (ret_valid),
      .ret_data    (ret_data),
      .ret_last    (ret_last),
      .m_data      (m_data),
      .word_valid  (word_valid),
      .crit_ready  (crit_ready),
      .wr_en       (wr_en),
      .wr_way      (wr_way),
      .wr_addr     (wr_addr),
      .refill_done (refill_done),
      .proto_err   (proto_err)
   );

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [1:0]        way;
      logic [LINE_W-1:0] line;
      logic              err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   logic model_err = 1'b0;

   task automatic checkOutput(input string name, input logic [LINE_W-1:0] act,
                              input logic [LINE_W-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_busy"},        128'(busy),        128'(1'b0));
      checkOutput({tag, "_mem_rd_req"},  128'(mem_rd_req),  128'(1'b0));
      checkOutput({tag, "_mem_rd_addr"}, 128'(mem_rd_addr), 128'(1'b0));
      checkOutput({tag, "_m_data"},      m_data,            128'(1'b0));
      checkOutput({tag, "_word_valid"},  128'(word_valid),  128'(1'b0));
      checkOutput({tag, "_crit_ready"},  128'(crit_ready),  128'(1'b0));
      checkOutput({tag, "_wr_en"},       128'(wr_en),       128'(1'b0));
      checkOutput({tag, "_wr_way"},      128'(wr_way),      128'(1'b0));
      checkOutput({tag, "_wr_addr"},     128'(wr_addr),     128'(1'b0));
      checkOutput({tag, "_refill_done"}, 128'(refill_done), 128'(1'b0));
      checkOutput({tag, "_proto_err"},   128'(proto_err),   128'(1'b0));
   endtask

   // One refill transaction; abort_after >= 0 resets the DUT before that beat.
   task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [1:0] way,
                                input int ack_delay, input int gap,
                                input logic [3:0] last_mask, input logic [LINE_W-1:0] line,
                                input bit stray_ack, input bit busy_miss, input int abort_after);
      logic [ADDR_W-1:0] line_addr;
      logic [3:0]        wv_exp;
      logic              exp_err;
      int                crit;
      int                waited;
      exp_t              e;
      line_addr = {addr[ADDR_W-1:4], 4'h0};
      crit      = int'(addr[3:2]);
      wv_exp    = 4'b0000;
      waited    = 0;
      while (busy === 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      checkOutput("idle_before_miss", 128'(busy), 128'(1'b0));

      exp_err = model_err;
      for (int i = 0; i < 4; i++) begin
         if (last_mask[i] != (i == 3)) exp_err = 1'b1;
      end
      e.addr = line_addr;
      e.way  = way;
      e.line = line;
      e.err  = exp_err;
      exp_q.push_back(e);
      model_err = exp_err;

      miss_addr = addr;
      miss_way  = way;
      miss_req  = 1'b1;
      tick();
      miss_req = 1'b0;
      checkOutput("req_asserted", 128'(mem_rd_req), 128'(1'b1));
      checkOutput("req_addr", 128'(mem_rd_addr), 128'(line_addr));
      checkOutput("busy_in_req", 128'(busy), 128'(1'b1));
      checkOutput("word_valid_cleared", 128'(word_valid), 128'(1'b0));

      for (int d = 0; d < ack_delay; d++) begin
         tick();
         checkOutput("req_held", 128'(mem_rd_req), 128'(1'b1));
         checkOutput("req_addr_stable", 128'(mem_rd_addr), 128'(line_addr));
      end

      mem_rd_ack = 1'b1;
      ret_valid  = stray_ack;
      ret_last   = stray_ack;
      ret_data   = 32'hDEAD_BEEF;
      tick();
      mem_rd_ack = 1'b0;
      ret_valid  = 1'b0;
      ret_last   = 1'b0;
      checkOutput("req_dropped", 128'(mem_rd_req), 128'(1'b0));
      checkOutput("ack_beat_ignored", 128'(word_valid), 128'(1'b0));

      for (int i = 0; i < 4; i++) begin
         if (i == abort_after) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            checkResetState("abort");
            for (int s = 0; s < 2; s++) begin
               ret_valid = 1'b1;
               ret_data  = $urandom;
               ret_last  = (s == 1);
               tick();
            end
            ret_valid = 1'b0;
            ret_last  = 1'b0;
            checkOutput("stray_word_valid", 128'(word_valid), 128'(1'b0));
            checkOutput("stray_m_data", m_data, 128'(1'b0));
            checkOutput("stray_busy", 128'(busy), 128'(1'b0));
            exp_q.delete(exp_q.size() - 1);
            model_err = 1'b0;
            return;
         end
         for (int g = 0; g < gap; g++) tick();
         if (busy_miss && i == 1) begin
            miss_req  = 1'b1;
            miss_way  = 2'b10;
            miss_addr = ~addr;
         end
         ret_valid = 1'b1;
         ret_data  = line[i*WORD_W +: WORD_W];
         ret_last  = last_mask[i];
         tick();
         ret_valid = 1'b0;
         ret_last  = 1'b0;
         miss_req  = 1'b0;
         wv_exp[i] = 1'b1;
         checkOutput("word_valid_step", 128'(word_valid), 128'(wv_exp));
         checkOutput("crit_ready", 128'(crit_ready), 128'(i >= crit));
      end

      checkOutput("wr_en_on_time", 128'(wr_en), 128'(1'b1));
      checkOutput("refill_done_on_time", 128'(refill_done), 128'(1'b1));
      tick();
      checkOutput("wr_en_one_cycle", 128'(wr_en), 128'(1'b0));
      checkOutput("refill_done_one_cycle", 128'(refill_done), 128'(1'b0));
      checkOutput("idle_after_write", 128'(busy), 128'(1'b0));
      checkOutput("word_valid_full", 128'(word_valid), 128'(4'b1111));

      ret_valid = 1'b1;
      ret_data  = $urandom;
      tick();
      ret_valid = 1'b0;
      checkOutput("m_data_held", m_data, line);
   endtask

   // Monitor: every line write must match the oldest outstanding refill.
   always @(negedge clk) begin
      exp_t m;
      if (!rst && wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_wr_en actual=1 required=0");
         end else begin
            m = exp_q.pop_front();
            checkOutput("sb_wr_addr", 128'(wr_addr), 128'(m.addr));
            checkOutput("sb_wr_way", 128'(wr_way), 128'(m.way));
            checkOutput("sb_m_data", m_data, m.line);
            checkOutput("sb_refill_done", 128'(refill_done), 128'(1'b1));
            checkOutput("sb_proto_err", 128'(proto_err), 128'(m.err));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [ADDR_W-1:0] addr;
      logic [1:0]        way;
      logic [LINE_W-1:0] line;
      logic [3:0]        lm;
      int                ab;
      repeat (3) tick();
      checkResetState("reset");
      rst = 1'b0;
      tick();

      $display("[TB] basic refill");
      applyStimulus(32'h0000_1234, 2'b01, 0, 0, 4'b1000,
                    {32'hA3A3_A3A3, 32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0}, 1'b0, 1'b0, -1);
      $display("[TB] critical word, gapped beats");
      applyStimulus(32'h0000_5678, 2'b10, 0, 2, 4'b1000,
                    {32'hB3B3_0003, 32'hB2B2_0002, 32'hB1B1_0001, 32'hB0B0_0000}, 1'b0, 1'b0, -1);
      $display("[TB] delayed ack with beat in ack cycle");
      applyStimulus(32'h8000_00F0, 2'b01, 5, 0, 4'b1000,
                    {32'hC3C3_C3C3, 32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C0C0}, 1'b1, 1'b0, -1);
      $display("[TB] miss while busy");
      applyStimulus(32'h1234_5604, 2'b01, 1, 1, 4'b1000,
                    {32'hD3D3_D3D3, 32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'hD0D0_D0D0}, 1'b0, 1'b1, -1);
      $display("[TB] early last");
      applyStimulus(32'h0000_0A0C, 2'b10, 0, 0, 4'b1010,
                    {32'hE3E3_E3E3, 32'hE2E2_E2E2, 32'hE1E1_E1E1, 32'hE0E0_E0E0}, 1'b0, 1'b0, -1);
      applyStimulus(32'h0000_0B00, 2'b01, 0, 0, 4'b1000,
                    {32'hF3F3_F3F3, 32'hF2F2_F2F2, 32'hF1F1_F1F1, 32'hF0F0_F0F0}, 1'b0, 1'b0, -1);
      checkOutput("proto_err_sticky", 128'(proto_err), 128'(1'b1));
      $display("[TB] mid-refill reset");
      applyStimulus(32'h0000_2228, 2'b10, 0, 0, 4'b1000,
                    {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000}, 1'b0, 1'b0, 2);
      applyStimulus(32'h0000_3334, 2'b01, 0, 0, 4'b1000,
                    {32'h2222_0003, 32'h2222_0002, 32'h2222_0001, 32'h2222_0000}, 1'b0, 1'b0, -1);

      $display("[TB] random refills");
      for (int n = 0; n < 24; n++) begin
         addr = $urandom;
         way  = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
         line = {$urandom, $urandom, $urandom, $urandom};
         lm   = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b1000;
         ab   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
         applyStimulus(addr, way, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), lm, line,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ab);
      end

      repeat (3) tick();
      checkOutput("pending_refills", 128'(exp_q.size()), 128'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
